// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions plus the state and geometry constants used by
// the physical-memory responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l1_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } pmem_state_t;

  localparam int PMEM_OFFSET_BITS = 4;

endpackage

// File: rtl/pmem_responder_line_array.sv
// Line-organised backing store: one synchronous write port, one registered read
// port. Deliberately unreset so contents survive a controller reset.
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_waddr,
  input  lc3b_l1_line           i_wdata,
  input  logic [INDEX_BITS-1:0] i_raddr,
  output lc3b_l1_line           o_rdata
);

  localparam int DEPTH = 1 << INDEX_BITS;

  lc3b_l1_line r_mem [DEPTH];
  lc3b_l1_line r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_responder.sv
// Responder side of the cache-to-memory line interface: fixed-latency single
// outstanding request, sticky read+write protocol flag, per-direction counters.
//
// Handshake: the requester raises pmem_read or pmem_write and holds it until a
// one-cycle pmem_resp; dropping both while BUSY aborts the request silently.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_l1_line pmem_wdata,
  output logic        pmem_resp,
  output lc3b_l1_line pmem_rdata,
  output logic        protocol_error,
  output logic [15:0] read_count,
  output logic [15:0] write_count
);

  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

  pmem_state_t           r_state;
  pmem_state_t           w_next_state;
  logic                  r_op_write;
  logic [INDEX_BITS-1:0] r_index;
  lc3b_l1_line           r_wdata;
  logic [7:0]            r_lat_cnt;
  lc3b_l1_line           r_rdata;
  logic                  r_protocol_error;
  logic [15:0]           r_read_count;
  logic [15:0]           r_write_count;

  logic                  w_req;
  logic                  w_accept;
  logic                  w_to_respond;
  logic                  w_resp;
  logic                  w_mem_we;
  logic [INDEX_BITS-1:0] w_addr_index;
  logic [INDEX_BITS-1:0] w_rd_index;
  lc3b_l1_line           w_mem_rdata;
  logic                  w_unused_addr;

  assign w_req         = pmem_read | pmem_write;
  assign w_addr_index  = pmem_address[INDEX_BITS+PMEM_OFFSET_BITS-1:PMEM_OFFSET_BITS];
  assign w_unused_addr = ^{pmem_address[PMEM_OFFSET_BITS-1:0],
                           pmem_address >> (INDEX_BITS + PMEM_OFFSET_BITS)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_next_state = BUSY;
      BUSY: begin
        if (!w_req)                w_next_state = IDLE;
        else if (r_lat_cnt == 8'd0) w_next_state = RESPOND;
      end
      RESPOND: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The array is addressed from the live bus in IDLE so the line is already
  // available by the last BUSY cycle, even with LATENCY=1.
  always_comb begin
    w_resp       = (r_state == RESPOND);
    w_mem_we     = w_resp & r_op_write;
    w_accept     = (r_state == IDLE) & w_req;
    w_to_respond = (r_state == BUSY) & w_req & (r_lat_cnt == 8'd0);
    w_rd_index   = (r_state == IDLE) ? w_addr_index : r_index;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_write       <= 1'b0;
      r_index          <= '0;
      r_wdata          <= '0;
      r_lat_cnt        <= 8'd0;
      r_rdata          <= '0;
      r_protocol_error <= 1'b0;
      r_read_count     <= 16'd0;
      r_write_count    <= 16'd0;
    end else begin
      if (w_accept) begin
        r_op_write <= pmem_write;
        r_index    <= w_addr_index;
        r_wdata    <= pmem_wdata;
        r_lat_cnt  <= LAT_LOAD;
        if (pmem_read && pmem_write) begin
          r_protocol_error <= 1'b1;
        end
      end else if (r_state == BUSY && r_lat_cnt != 8'd0) begin
        r_lat_cnt <= r_lat_cnt - 8'd1;
      end

      if (w_to_respond && !r_op_write) begin
        r_rdata <= w_mem_rdata;
      end

      if (w_resp) begin
        if (r_op_write) r_write_count <= r_write_count + 16'd1;
        else            r_read_count  <= r_read_count + 16'd1;
      end
    end
  end

  pmem_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_line_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_index),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_index),
    .o_rdata (w_mem_rdata)
  );

  assign pmem_resp      = w_resp;
  assign pmem_rdata     = r_rdata;
  assign protocol_error = r_protocol_error;
  assign read_count     = r_read_count;
  assign write_count    = r_write_count;

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: instance "a" at LATENCY=10, instance "b"
// at LATENCY=1 for back-to-back and mid-BUSY reset scenarios.
module tb_pmem_responder;
  import lc3b_types::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_read, a_write, a_resp, a_perr;
  lc3b_word    a_addr;
  lc3b_l1_line a_wdata, a_rdata;
  logic [15:0] a_rcnt, a_wcnt;

  logic        b_rst_n, b_read, b_write, b_resp, b_perr;
  lc3b_word    b_addr;
  lc3b_l1_line b_wdata, b_rdata;
  logic [15:0] b_rcnt, b_wcnt;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [127:0] exp_q[$];

  lc3b_l1_line line_d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  lc3b_l1_line line_a = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  lc3b_l1_line line_b = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
  lc3b_l1_line line_c = 128'hCCCC_CCCC_DEAD_BEEF_CCCC_CCCC_DEAD_BEEF;
  lc3b_l1_line line_e = 128'hE000_0000_0000_0000_0000_0000_0000_000E;
  lc3b_l1_line line_f = 128'hF00D_FACE_1234_5678_9ABC_DEF0_0F0F_F0F0;

  pmem_responder #(.LATENCY(10), .INDEX_BITS(6)) dut_a (
    .clk            (clk),
    .reset_n        (a_rst_n),
    .pmem_read      (a_read),
    .pmem_write     (a_write),
    .pmem_address   (a_addr),
    .pmem_wdata     (a_wdata),
    .pmem_resp      (a_resp),
    .pmem_rdata     (a_rdata),
    .protocol_error (a_perr),
    .read_count     (a_rcnt),
    .write_count    (a_wcnt)
  );

  pmem_responder #(.LATENCY(1), .INDEX_BITS(6)) dut_b (
    .clk            (clk),
    .reset_n        (b_rst_n),
    .pmem_read      (b_read),
    .pmem_write     (b_write),
    .pmem_address   (b_addr),
    .pmem_wdata     (b_wdata),
    .pmem_resp      (b_resp),
    .pmem_rdata     (b_rdata),
    .protocol_error (b_perr),
    .read_count     (b_rcnt),
    .write_count    (b_wcnt)
  );

  // scoreboard compare
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input lc3b_word addr, input lc3b_l1_line wd);
    if (sel) begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd;
    end else begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd;
    end
  endtask

  function automatic logic get_resp(input bit sel);
    return sel ? b_resp : a_resp;
  endfunction

  function automatic lc3b_l1_line get_rdata(input bit sel);
    return sel ? b_rdata : a_rdata;
  endfunction

  // Issue one request, measure cycles from the acceptance edge to pmem_resp,
  // drop the request in the RESPOND cycle, and step into the following cycle.
  task automatic xfer(input bit sel, input logic rd, input logic wr,
                      input lc3b_word addr, input lc3b_l1_line wd,
                      output int lat, output lc3b_l1_line rdata);
    drive(sel, rd, wr, addr, wd);
    lat   = 0;
    rdata = '0;
    tick();
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (get_resp(sel)) begin
        lat   = i;
        rdata = get_rdata(sel);
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, addr, wd);
    tick();
  endtask

  initial begin
    int          lat;
    int          pulses;
    lc3b_l1_line rd;

    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, '0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, '0);
    repeat (3) tick();
    chk("rst_resp",  a_resp, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_perr",  a_perr, 0);
    chk("rst_rcnt",  a_rcnt, 0);
    chk("rst_wcnt",  a_wcnt, 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // read after reset, latency and pulse width
    exp_q.push_back('0);
    xfer(1'b0, 1'b1, 1'b0, 16'h0040, '0, lat, rd);
    chk("rd0040_latency", lat, 10);
    chk("rd0040_data", rd, exp_q.pop_front());
    chk("rd0040_pulse_width", a_resp, 0);
    chk("rd0040_rcnt", a_rcnt, 1);

    // write then read with different byte offset in the same line
    xfer(1'b0, 1'b0, 1'b1, 16'h0230, line_d, lat, rd);
    chk("wr0230_latency", lat, 10);
    chk("wr0230_wcnt", a_wcnt, 1);
    exp_q.push_back(line_d);
    xfer(1'b0, 1'b1, 1'b0, 16'h0238, '0, lat, rd);
    chk("rd0238_data", rd, exp_q.pop_front());
    chk("rd0238_rcnt", a_rcnt, 2);

    // aliasing: 0x0410 maps to index 1 like 0x0010
    xfer(1'b0, 1'b0, 1'b1, 16'h0010, line_a, lat, rd);
    exp_q.push_back(line_a);
    xfer(1'b0, 1'b1, 1'b0, 16'h0410, '0, lat, rd);
    chk("alias0410_data", rd, exp_q.pop_front());
    chk("alias_wcnt", a_wcnt, 2);
    chk("alias_rcnt", a_rcnt, 3);

    // abort: write held 3 cycles then dropped
    xfer(1'b0, 1'b0, 1'b1, 16'h0100, line_b, lat, rd);
    chk("wr0100_wcnt", a_wcnt, 3);
    drive(1'b0, 1'b0, 1'b1, 16'h0100, line_c);
    pulses = 0;
    repeat (3) begin
      tick();
      pulses += int'(a_resp);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0100, line_c);
    repeat (15) begin
      tick();
      pulses += int'(a_resp);
    end
    chk("abort_no_resp", pulses, 0);
    chk("abort_wcnt", a_wcnt, 3);
    exp_q.push_back(line_b);
    xfer(1'b0, 1'b1, 1'b0, 16'h0100, '0, lat, rd);
    chk("abort_rd0100_data", rd, exp_q.pop_front());
    chk("abort_rcnt", a_rcnt, 4);
    chk("perr_before_both", a_perr, 0);

    // simultaneous read+write executes as a write; rdata keeps the last read
    xfer(1'b0, 1'b1, 1'b1, 16'h0020, line_e, lat, rd);
    chk("both_latency", lat, 10);
    chk("both_rdata_held", rd, line_b);
    chk("both_perr", a_perr, 1);
    chk("both_wcnt", a_wcnt, 4);
    chk("both_rcnt", a_rcnt, 4);
    exp_q.push_back(line_e);
    xfer(1'b0, 1'b1, 1'b0, 16'h0020, '0, lat, rd);
    chk("both_rd0020_data", rd, exp_q.pop_front());
    chk("both_perr_sticky", a_perr, 1);
    chk("both_rd_rcnt", a_rcnt, 5);

    // LATENCY=1: seed a line, then hold read continuously
    xfer(1'b1, 1'b0, 1'b1, 16'h0050, line_f, lat, rd);
    chk("l1_wr_latency", lat, 1);
    chk("l1_wr_wcnt", b_wcnt, 1);
    drive(1'b1, 1'b1, 1'b0, 16'h0050, '0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("b2b_resp_k%0d", k), b_resp, (k % 3 == 2) ? 1 : 0);
      if (k % 3 == 2) chk($sformatf("b2b_rdata_k%0d", k), b_rdata, line_f);
      if (k == 4) b_addr = 16'h0060;
      if (k == 5) b_addr = 16'h0050;
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0050, '0);
    chk("b2b_rcnt", b_rcnt, 4);
    tick();

    // asynchronous reset while BUSY
    drive(1'b1, 1'b1, 1'b0, 16'h0050, '0);
    tick();
    b_rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 16'h0050, '0);
    #1;
    chk("midrst_resp", b_resp, 0);
    chk("midrst_rdata", b_rdata, 0);
    chk("midrst_rcnt", b_rcnt, 0);
    chk("midrst_wcnt", b_wcnt, 0);
    tick();
    tick();
    b_rst_n = 1'b1;
    pulses = 0;
    repeat (4) begin
      tick();
      pulses += int'(b_resp);
    end
    chk("midrst_no_resp", pulses, 0);
    xfer(1'b1, 1'b1, 1'b0, 16'h0050, '0, lat, rd);
    chk("midrst_storage_intact", rd, line_f);
    chk("midrst_rd_latency", lat, 1);
    chk("midrst_rd_rcnt", b_rcnt, 1);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pmem_responder.md
Name: pmem_responder

Overview:
- Responder end of the physical-memory line interface that the cache hierarchy drives (pmem_read/pmem_write/pmem_address/pmem_wdata in, pmem_resp/pmem_rdata out).
- Holds a line-organised backing store and services one 128-bit line request at a time with programmable fixed latency.
- Used as the synthesizable memory model for full-system simulation and FPGA bring-up.
- Also provides a protocol checker and per-direction transfer counters.

Parameters:
- LATENCY, 10, cycles from request acceptance to pmem_resp; legal range 1..255.
- INDEX_BITS, 6, log2 of the number of lines stored (default 64 lines, 1 KiB).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pmem_read  in  1  line read request; held until pmem_resp.
- pmem_write  in  1  line write request; held until pmem_resp.
- pmem_address  in  16 (lc3b_word)  byte address; bits [3:0] ignored (line aligned).
- pmem_wdata  in  128 (lc3b_l1_line)  write line data.
- pmem_resp  out  1  one-cycle completion pulse.
- pmem_rdata  out  128 (lc3b_l1_line)  read line data; valid while pmem_resp is high.
- protocol_error  out  1  sticky flag; set on simultaneous read and write.
- read_count  out  16  completed reads; wraps at 0xFFFF -> 0.
- write_count  out  16  completed writes; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (async, reset_n low) forces: state IDLE, pmem_resp 0, pmem_rdata 0, protocol_error 0, both counters 0, latency counter 0.
- Reset does not touch storage contents. The simulation initial value of every line is 0.
- Line index is pmem_address[INDEX_BITS+3:4]. Higher address bits are ignored, so addresses alias modulo the array size.
- FSM states:
  - IDLE: if pmem_read or pmem_write is high at the edge, capture the op, index and wdata; load counter with LATENCY-1; go to BUSY.
  - BUSY: if both requests are low, abort: return to IDLE with no response and no storage change. Otherwise, if counter==0, go to RESPOND; else decrement the counter.
  - RESPOND: pmem_resp=1 for exactly this cycle.
    - Read: pmem_rdata = storage[captured index].
    - Write: storage[captured index] = captured wdata at the end of this cycle.
    - Increment the matching counter. Next state is IDLE.
- Latency: a request first sampled in IDLE at edge t gives pmem_resp high during cycle t+LATENCY. With LATENCY=1, resp is in the cycle after acceptance.
- Address and wdata are captured at acceptance. Later changes while BUSY are ignored.
- A request still high in the IDLE cycle after RESPOND is treated as a new request. There is minimum one IDLE cycle between responses.
- Simultaneous read and write at acceptance: set protocol_error (sticky until reset) and execute as a write.
- pmem_rdata is registered. It holds its last read value outside RESPOND and is not changed by writes.
- Read-after-write to the same line returns the new data. The write commits before the next IDLE acceptance.

Decomposition:
- lc3b_types package: lc3b_word and lc3b_l1_line are reused.
  - Add a pmem_state_t enum (IDLE, BUSY, RESPOND).
  - Add PMEM_OFFSET_BITS = 4.
- Sub-module pmem_line_array: clocked array of 2^INDEX_BITS lines with one write port and one registered read port. It has no reset. The FSM and counters stay in pmem_responder.

Test Plan:
- Read after reset, address 0x0040, LATENCY=10:
  - pmem_resp rises exactly 10 cycles after acceptance, for 1 cycle.
  - pmem_rdata = 0; read_count = 1.
- Write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 to 0x0230, then read 0x0238:
  - Read returns the same line (offset ignored).
  - write_count = 1, read_count = 1.
- Aliasing, INDEX_BITS=6:
  - Write line A to 0x0010, then read 0x0410.
  - Returns A (same index 1).
- Abort:
  - Assert pmem_write to 0x0100, drop it after 3 cycles.
  - No pmem_resp; a subsequent read of 0x0100 returns the prior contents; write_count unchanged.
- Both read and write asserted to 0x0020:
  - protocol_error = 1 and stays high.
  - Write commits; pmem_resp after LATENCY.
- Back-to-back, LATENCY=1, read held continuously:
  - resp pulses every 3 cycles (accept, RESPOND, IDLE).
  - Address change during BUSY is ignored.
  - reset_n pulsed low mid-BUSY clears state with no resp; storage is intact.
